// File: rtl/alu_issue_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_unit                                               |
// | Description : Issue unit for an external 32-bit ALU. Accepts one request   |
// |               every three cycles, reads the operands from an 8 x 32-bit    |
// |               register file (r0 hard-wired to zero), drives the ALU with   |
// |               registered operands and writes the result back.             |
// |               IDLE accepts a request, EXEC captures the ALU result, and    |
// |               WB raises done and commits at the edge that leaves it.       |
// | Ports       : clk, rst            - clock, synchronous active-high reset   |
// |               in_valid/in_ready   - issue handshake                        |
// |               in_op,in_rs,in_rt,in_rd - opcode and register indices        |
// |               alu_a,alu_b,alu_op  - registered ALU operands and opcode     |
// |               alu_result,alu_zero,alu_overflow - ALU response              |
// |               done,done_zero,done_ovf,done_illegal - completion pulse/flags|
// |               ovf_sticky          - any overflow seen since reset          |
// |               dbg_sel/dbg_data    - combinational register-file read port  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_issue_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [2:0]  in_rs,
    input  logic [2:0]  in_rt,
    input  logic [2:0]  in_rd,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        done,
    output logic        done_zero,
    output logic        done_ovf,
    output logic        done_illegal,
    output logic        ovf_sticky,
    input  logic [2:0]  dbg_sel,
    output logic [31:0] dbg_data
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_WB   = 2'd2;

    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_SUB  = 3'b110;

    logic [1:0]  r_state;
    logic [31:0] r_regs [8];
    logic [2:0]  r_rd;
    logic        r_illegal;
    logic [31:0] r_result;

    logic        w_illegal;
    logic        w_ovf;

    // Opcodes 011, 100 and 101 have no defined ALU function.
    assign w_illegal = (in_op == 3'b011) || (in_op == 3'b100) || (in_op == 3'b101);

    // The ALU overflow flag is meaningless outside ADD/SUB, so it is masked here.
    assign w_ovf = alu_overflow && ((alu_op == c_OP_ADD) || (alu_op == c_OP_SUB));

    assign in_ready = (r_state == c_ST_IDLE);

    // r_regs[0] is cleared by reset and never written, so it always reads zero.
    assign dbg_data = r_regs[dbg_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            r_rd         <= '0;
            r_illegal    <= 1'b0;
            r_result     <= '0;
            done         <= 1'b0;
            done_zero    <= 1'b0;
            done_ovf     <= 1'b0;
            done_illegal <= 1'b0;
            ovf_sticky   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        // Operands are read here; the previous write-back has
                        // already landed, so no forwarding path is needed.
                        alu_a     <= r_regs[in_rs];
                        alu_b     <= r_regs[in_rt];
                        alu_op    <= in_op;
                        r_rd      <= in_rd;
                        r_illegal <= w_illegal;
                        r_state   <= c_ST_EXEC;
                    end
                end
                c_ST_EXEC: begin
                    r_result     <= alu_result;
                    done         <= 1'b1;
                    done_zero    <= alu_zero;
                    done_ovf     <= w_ovf;
                    done_illegal <= r_illegal;
                    if (w_ovf) begin
                        ovf_sticky <= 1'b1;
                    end
                    r_state      <= c_ST_WB;
                end
                c_ST_WB: begin
                    // done_ovf/done_illegal hold the captured flags for this op.
                    if (!done_ovf && !done_illegal && (r_rd != 3'd0)) begin
                        r_regs[r_rd] <= r_result;
                    end
                    done         <= 1'b0;
                    done_zero    <= 1'b0;
                    done_ovf     <= 1'b0;
                    done_illegal <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_issue_unit                                            |
// | Description : Self-checking bench for alu_issue_unit. Provides a          |
// |               behavioural 32-bit ALU (with a seed-injection mode used to  |
// |               preload registers from r0), a register-file model and a      |
// |               scoreboard of expected completions.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_issue_unit;

    localparam logic [2:0] c_ADD = 3'b010;
    localparam logic [2:0] c_SUB = 3'b110;
    localparam logic [2:0] c_AND = 3'b000;
    localparam logic [2:0] c_OR  = 3'b001;
    localparam logic [2:0] c_SLT = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0, in_rs = '0, in_rt = '0, in_rd = '0, dbg_sel = '0;
    logic [31:0] alu_a, alu_b, alu_result, dbg_data;
    logic [2:0]  alu_op;
    logic        alu_zero, alu_overflow;
    logic        done, done_zero, done_ovf, done_illegal, ovf_sticky;

    always #5 clk = ~clk;

    alu_issue_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .done(done), .done_zero(done_zero), .done_ovf(done_ovf),
        .done_illegal(done_illegal), .ovf_sticky(ovf_sticky),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Seed mode forces the ALU result so registers can be loaded from r0.
    logic        seed_en = 1'b0;
    logic [31:0] seed_val = '0;

    // Behavioural ALU: returns {overflow, result}. Non-ADD/SUB ops raise a
    // spurious overflow on purpose; the unit must ignore it.
    function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op, input logic sd,
                                           input logic [31:0] sv);
        logic [31:0] r;
        logic        o;
        if (sd) return {1'b0, sv};
        case (op)
            3'b000:  begin r = a & b; o = 1'b1; end
            3'b001:  begin r = a | b; o = 1'b1; end
            3'b010:  begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            3'b110:  begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            3'b111:  begin r = {31'b0, ($signed(a) < $signed(b))}; o = 1'b1; end
            default: begin r = a ^ b; o = 1'b1; end
        endcase
        return {o, r};
    endfunction

    always_comb begin
        {alu_overflow, alu_result} = alu_fn(alu_a, alu_b, alu_op, seed_en, seed_val);
    end
    assign alu_zero = (alu_result == 32'd0);

    typedef struct {
        logic [31:0] a, b, res;
        logic [2:0]  rd;
        logic        z, o, ill, wr;
        int          done_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rf [8];
    logic        last_z, last_o, last_i;

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t it;
        if (done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done at cycle %0d: done=1 with no op outstanding", cyc);
            end else begin
                it = sb.pop_front();
                if ({done_zero, done_ovf, done_illegal} !== {it.z, it.o, it.ill} ||
                    alu_a !== it.a || alu_b !== it.b || cyc !== it.done_cyc) begin
                    errors++;
                    $display("FAIL completion: got zov_ill=%b%b%b a=%h b=%h cyc=%0d, expected %b%b%b a=%h b=%h cyc=%0d",
                             done_zero, done_ovf, done_illegal, alu_a, alu_b, cyc,
                             it.z, it.o, it.ill, it.a, it.b, it.done_cyc);
                end
                if (it.wr) model_rf[it.rd] = it.res;
                last_z = done_zero;
                last_o = done_ovf;
                last_i = done_illegal;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input bit hold, output int t);
        int          n;
        exp_t        e;
        logic [32:0] r;
        t = -1;
        @(negedge clk);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%b, required 1 within 10 cycles", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        t = cyc;
        r = alu_fn(model_rf[rs], model_rf[rt], op, seed_en, seed_val);
        e.a = model_rf[rs];
        e.b = model_rf[rt];
        e.res = r[31:0];
        e.rd = rd;
        e.ill = (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
        e.o = ((op == c_ADD) || (op == c_SUB)) && r[32];
        e.z = (r[31:0] == 32'd0);
        e.wr = !e.o && !e.ill && (rd != 3'd0);
        e.done_cyc = t + 1;
        sb.push_back(e);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (sb.size() != 0 && n < 20);
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: %0d ops outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic read_reg(input logic [2:0] i, output logic [31:0] v);
        dbg_sel = i;
        #1;
        v = dbg_data;
    endtask

    task automatic preload(input logic [2:0] rd, input logic [31:0] val);
        int t;
        seed_en = 1'b1;
        seed_val = val;
        send(c_ADD, 3'd0, 3'd0, rd, 1'b0, t);
        wait_idle();
        seed_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, done, done_zero, done_ovf, done_illegal, ovf_sticky} !== 6'b100000 ||
            alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: rdy/done/z/o/i/sticky=%b%b%b%b%b%b a=%h b=%h op=%b, required 100000 and zeros",
                     in_ready, done, done_zero, done_ovf, done_illegal, ovf_sticky, alu_a, alu_b, alu_op);
        end
        for (int i = 0; i < 8; i++) begin
            read_reg(i[2:0], v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL reset_reg r%0d: got %h, required 0", i, v);
            end
            model_rf[i] = '0;
        end
    endtask

    task automatic test_add();
        int t;
        logic [31:0] v;
        preload(3'd1, 32'd5);
        preload(3'd2, 32'd7);
        send(c_ADD, 3'd1, 3'd2, 3'd3, 1'b0, t);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL add_exec_cycle: in_ready=%b done=%b, required 0 0", in_ready, done);
        end
        wait_idle();
        read_reg(3'd3, v);
        checks++;
        if (v !== 32'd12 || last_z !== 1'b0) begin
            errors++;
            $display("FAIL add_r3: got %h zero=%b, required 0000000c zero=0", v, last_z);
        end
        send(c_AND, 3'd1, 3'd2, 3'd7, 1'b0, t);
        wait_idle();
        read_reg(3'd7, v);
        checks++;
        if (v !== 32'd5 || last_o !== 1'b0) begin
            errors++;
            $display("FAIL and_r7: got %h ovf=%b, required 00000005 ovf=0", v, last_o);
        end
        send(c_OR, 3'd1, 3'd2, 3'd7, 1'b0, t);
        wait_idle();
        read_reg(3'd7, v);
        checks++;
        if (v !== 32'd7 || last_o !== 1'b0) begin
            errors++;
            $display("FAIL or_r7: got %h ovf=%b, required 00000007 ovf=0", v, last_o);
        end
    endtask

    task automatic test_sub_zero();
        int t;
        logic [31:0] v;
        preload(3'd1, 32'd9);
        preload(3'd2, 32'd9);
        preload(3'd4, 32'h55);
        preload(3'd5, 32'h33);
        send(c_SUB, 3'd1, 3'd2, 3'd4, 1'b0, t);
        wait_idle();
        read_reg(3'd4, v);
        checks++;
        if (v !== 32'd0 || last_z !== 1'b1) begin
            errors++;
            $display("FAIL sub_zero_r4: got %h zero=%b, required 00000000 zero=1", v, last_z);
        end
        send(c_SLT, 3'd1, 3'd2, 3'd5, 1'b0, t);
        wait_idle();
        read_reg(3'd5, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL slt_equal_r5: got %h, required 00000000", v);
        end
        preload(3'd1, 32'hFFFF_FFFF);
        send(c_SLT, 3'd1, 3'd2, 3'd6, 1'b0, t);
        wait_idle();
        read_reg(3'd6, v);
        checks++;
        if (v !== 32'd1) begin
            errors++;
            $display("FAIL slt_signed_r6: got %h, required 00000001", v);
        end
    endtask

    task automatic test_r0_illegal();
        int t;
        logic [31:0] v;
        send(c_ADD, 3'd1, 3'd2, 3'd0, 1'b0, t);
        wait_idle();
        read_reg(3'd0, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL r0_write: got %h, required 00000000", v);
        end
        send(3'b100, 3'd1, 3'd2, 3'd3, 1'b0, t);
        wait_idle();
        checks++;
        if (last_i !== 1'b1 || last_o !== 1'b0 || ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL illegal_flags: illegal=%b ovf=%b sticky=%b, required 1 0 0", last_i, last_o, ovf_sticky);
        end
        for (int i = 0; i < 8; i++) begin
            read_reg(i[2:0], v);
            checks++;
            if (v !== model_rf[i]) begin
                errors++;
                $display("FAIL illegal_no_write r%0d: got %h, required %h", i, v, model_rf[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int t;
        logic [31:0] v;
        preload(3'd1, 32'h7FFF_FFFF);
        preload(3'd2, 32'd1);
        preload(3'd5, 32'hABC);
        send(c_ADD, 3'd1, 3'd2, 3'd5, 1'b0, t);
        wait_idle();
        read_reg(3'd5, v);
        checks++;
        if (v !== 32'hABC || last_o !== 1'b1 || ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL ovf_add_r5: got %h ovf=%b sticky=%b, required 00000abc 1 1", v, last_o, ovf_sticky);
        end
        send(c_ADD, 3'd2, 3'd2, 3'd7, 1'b0, t);
        wait_idle();
        read_reg(3'd7, v);
        checks++;
        if (v !== 32'd2 || last_o !== 1'b0 || ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky_hold: r7=%h ovf=%b sticky=%b, required 00000002 0 1", v, last_o, ovf_sticky);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        logic [31:0] v;
        preload(3'd1, 32'd5);
        preload(3'd2, 32'd7);
        send(c_ADD, 3'd1, 3'd2, 3'd3, 1'b1, t1);
        send(c_ADD, 3'd3, 3'd3, 3'd6, 1'b0, t2);
        checks++;
        if (t2 !== t1 + 3) begin
            errors++;
            $display("FAIL b2b_accept: second accepted at edge %0d, required %0d", t2, t1 + 3);
        end
        wait_idle();
        read_reg(3'd6, v);
        checks++;
        if (v !== 32'd24) begin
            errors++;
            $display("FAIL b2b_r6: got %h, required 00000018", v);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        logic [31:0] v;
        preload(3'd1, 32'd5);
        preload(3'd2, 32'd7);
        send(c_ADD, 3'd1, 3'd2, 3'd7, 1'b0, t);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 8; i++) model_rf[i] = '0;
        @(negedge clk);
        checks++;
        if ({in_ready, done, done_zero, done_ovf, done_illegal, ovf_sticky} !== 6'b100000 ||
            alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'd0) begin
            errors++;
            $display("FAIL midop_reset: rdy/done/z/o/i/sticky=%b%b%b%b%b%b a=%h b=%h op=%b, required 100000 and zeros",
                     in_ready, done, done_zero, done_ovf, done_illegal, ovf_sticky, alu_a, alu_b, alu_op);
        end
        repeat (4) @(negedge clk);
        read_reg(3'd7, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL midop_r7: got %h, required 00000000", v);
        end
        // Reset must win over a simultaneous request in IDLE.
        @(negedge clk);
        in_op = c_ADD; in_rs = 3'd0; in_rt = 3'd0; in_rd = 3'd1;
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_priority: in_ready=%b, required 1", in_ready);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_zero();
        test_r0_illegal();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 in_valid  input  1  issue request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 in_op  input  3  ALU operation code, passed unchanged to the ALU.
REQ-007 in_rs, in_rt, in_rd  input  3 each  source A, source B and destination register indices.
REQ-008 alu_a, alu_b  output  32 each  registered operands to the 32-bit ALU.
REQ-009 alu_op  output  3  registered operation code to the ALU.
REQ-010 alu_result  input  32  ALU result, combinational from alu_a, alu_b and alu_op.
REQ-011 alu_zero, alu_overflow  input  1 each  ALU flags.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 done_zero, done_ovf, done_illegal  output  1 each  flags of the completed op, valid while done=1.
REQ-014 ovf_sticky  output  1  set by any overflow; cleared only by rst.
REQ-015 dbg_sel  input  3; dbg_data  output  32  combinational register-file read port.

Function
REQ-016 The register file SHALL hold 8 x 32-bit registers; r0 SHALL read 0, and writes to r0 SHALL be discarded.
REQ-017 Legal ops SHALL be: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; 011, 100 and 101 SHALL be illegal.
REQ-018 The FSM SHALL have three states, IDLE, EXEC and WB, with in_ready=1 only in IDLE.
REQ-019 IDLE: on in_valid=1, the block SHALL register alu_a=R[in_rs], alu_b=R[in_rt], alu_op=in_op, rd and the illegal flag, then go to EXEC.
REQ-020 EXEC: the block SHALL capture alu_result, alu_zero and alu_overflow into internal registers at the clock edge, then go to WB.
REQ-021 WB: done SHALL be 1 for exactly this cycle, and the done_* outputs SHALL show the captured flags.
REQ-022 WB: at the edge leaving WB, the block SHALL write the captured result into R[rd] unless overflow=1 or illegal=1, then return to IDLE.
REQ-023 Latency SHALL be as follows: request accepted at edge T; done is high in cycle T+2; the write is visible on dbg_data and to the next issue from cycle T+3.
REQ-024 Throughput SHALL be one op per 3 cycles, with no forwarding needed because the write completes before the next acceptance.
REQ-025 For an illegal op, the ALU SHALL still be driven, done_illegal SHALL be 1, and no write SHALL occur; an illegal op SHALL NOT set ovf_sticky.
REQ-026 Overflow SHALL be honoured only for ADD and SUB; for other ops, alu_overflow SHALL be ignored (done_ovf=0).
REQ-027 When rs, rt and rd are equal, the operands SHALL be the pre-write value.
REQ-028 in_valid outside IDLE SHALL be ignored; the requester holds its request until in_ready=1.
REQ-029 alu_a, alu_b and alu_op SHALL stay stable from EXEC through WB.

Reset
REQ-030 On rst=1 at a clock edge, the state SHALL go to IDLE and in_ready SHALL be 1 in the following cycle.
REQ-031 Reset SHALL clear to 0: done, done_zero, done_ovf, done_illegal, ovf_sticky, alu_a, alu_b, alu_op and all registers.
REQ-032 rst asserted in EXEC or WB SHALL abort the op with no register write and no done pulse.
REQ-033 rst SHALL take priority over a simultaneous in_valid.

Verification
REQ-034 Scenario, ADD: preload R1=5 and R2=7 via ADD from r0-based seeds, then issue ADD rs=1 rt=2 rd=3 -> done at T+2, done_zero=0, R3=12 at T+3.
REQ-035 Scenario, SUB zero: R1=R2=9, issue SUB rd=4 -> done_zero=1 and R4=0; then issue SLT rs=1 rt=2 -> result 0.
REQ-036 Scenario, overflow: R1=0x7FFFFFFF, R2=1, issue ADD rd=5 -> done_ovf=1, R5 unchanged, ovf_sticky=1 until rst.
REQ-037 Scenario, r0 and illegal: issue ADD rd=0 -> R0 reads 0; issue op 100 -> done_illegal=1 and no register changes.
REQ-038 Scenario, back-to-back dependency: ADD rd=3, then with in_valid held, ADD rs=3 rt=3 rd=6 -> second accepted at T+3, R6=24.
REQ-039 Scenario, reset mid-op: rst during EXEC -> no done, rd unchanged, in_ready=1 next cycle, all outputs 0.
